// File: rtl/frame_sequencer.sv
// Frame sequencer: generates the sampling time base and drives the converter
// enable chain (conv_in -> lag -> conv_out/cancel) once per frame, with
// per-stage ready timeouts and overrun detection at each frame start.
module frame_sequencer #(
    parameter int unsigned CNT_W         = 13,
    parameter int unsigned PULSE_LEN     = 2,
    parameter int unsigned TIMEOUT_IN    = 32,
    parameter int unsigned TIMEOUT_LAG   = 160,
    parameter int unsigned WARMUP_FRAMES = 3,
    parameter int unsigned STAT_W        = 16
) (
    input  logic              clk_operation,
    input  logic              rst,
    input  logic [CNT_W-1:0]  sampling_cycle,
    input  logic              ready_conv_in,
    input  logic              ready_lag,
    output logic [CNT_W-1:0]  sampling_cycle_counter,
    output logic              sampling_light,
    output logic              enable_conv_in,
    output logic              enable_lag,
    output logic              enable_conv_out,
    output logic              enable_cancel,
    output logic              enable_sampling,
    output logic              busy,
    output logic [STAT_W-1:0] frame_count,
    output logic [STAT_W-1:0] timeout_count
);

    localparam int unsigned STEP_MAX_A = (TIMEOUT_LAG > TIMEOUT_IN) ? TIMEOUT_LAG : TIMEOUT_IN;
    localparam int unsigned STEP_MAX   = (STEP_MAX_A > PULSE_LEN) ? STEP_MAX_A : PULSE_LEN;
    localparam int unsigned STEP_W     = $clog2(STEP_MAX + 1);
    localparam int unsigned WARM_W     = $clog2(WARMUP_FRAMES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPulseIn,
        StWaitIn,
        StPulseLag,
        StWaitLag
    } state_e;

    state_e             state_q;
    logic [STEP_W-1:0]  step_q;
    logic [WARM_W-1:0]  warm_q;
    logic               run_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   eff_cycle;
    logic               light_q;
    logic               en_in_q;
    logic               en_lag_q;
    logic               en_out_q;
    logic               en_cancel_q;
    logic               en_samp_q;
    logic [STAT_W-1:0]  frame_q;
    logic [STAT_W-1:0]  timeout_q;
    logic [STAT_W-1:0]  timeout_inc;
    logic               frame_start;

    // Frame length clamp and counter next-state; the first clock after reset holds 0
    always_comb begin
        eff_cycle = (sampling_cycle < CNT_W'(2)) ? CNT_W'(2) : sampling_cycle;
        cnt_d     = '0;
        if (run_q && (cnt_q < eff_cycle - CNT_W'(1))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Time base: counter and frame-start strobe registered together
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            light_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            light_q <= (cnt_d == '0);
        end
    end

    assign frame_start = light_q;
    assign timeout_inc = (timeout_q == '1) ? timeout_q : timeout_q + STAT_W'(1);

    // Sequencer FSM with registered enables, warmup and statistics
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            warm_q      <= '0;
            en_in_q     <= 1'b0;
            en_lag_q    <= 1'b0;
            en_out_q    <= 1'b0;
            en_cancel_q <= 1'b0;
            en_samp_q   <= 1'b0;
            frame_q     <= '0;
            timeout_q   <= '0;
        end else begin
            if (frame_start && (warm_q < WARM_W'(WARMUP_FRAMES))) begin
                warm_q <= warm_q + WARM_W'(1);
            end
            if (frame_start && (warm_q == WARM_W'(WARMUP_FRAMES - 1))) begin
                en_samp_q <= 1'b1;
            end

            // A frame start always restarts the chain; if busy it counts as an overrun
            if (frame_start) begin
                if (state_q != StIdle) begin
                    timeout_q <= timeout_inc;
                end
                state_q  <= StPulseIn;
                step_q   <= '0;
                en_in_q  <= 1'b1;
                en_lag_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        step_q <= '0;
                    end
                    StPulseIn: begin
                        if (step_q == STEP_W'(PULSE_LEN - 1)) begin
                            state_q <= StWaitIn;
                            step_q  <= '0;
                            en_in_q <= 1'b0;
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                    StWaitIn: begin
                        if (ready_conv_in) begin
                            state_q  <= StPulseLag;
                            step_q   <= '0;
                            en_lag_q <= 1'b1;
                        end else if (step_q == STEP_W'(TIMEOUT_IN - 1)) begin
                            state_q   <= StIdle;
                            timeout_q <= timeout_inc;
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                    StPulseLag: begin
                        if (step_q == STEP_W'(PULSE_LEN - 1)) begin
                            state_q  <= StWaitLag;
                            step_q   <= '0;
                            en_lag_q <= 1'b0;
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                    StWaitLag: begin
                        if (ready_lag) begin
                            state_q     <= StIdle;
                            en_out_q    <= 1'b1;
                            en_cancel_q <= 1'b1;
                            frame_q     <= frame_q + STAT_W'(1);
                        end else if (step_q == STEP_W'(TIMEOUT_LAG - 1)) begin
                            state_q   <= StIdle;
                            timeout_q <= timeout_inc;
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        en_in_q  <= 1'b0;
                        en_lag_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sampling_cycle_counter = cnt_q;
    assign sampling_light         = light_q;
    assign enable_conv_in         = en_in_q;
    assign enable_lag             = en_lag_q;
    assign enable_conv_out        = en_out_q;
    assign enable_cancel          = en_cancel_q;
    assign enable_sampling        = en_samp_q;
    assign busy                   = (state_q != StIdle);
    assign frame_count            = frame_q;
    assign timeout_count          = timeout_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed segments plus randomized stimulus,
// checked every cycle against a phase/elapsed-time reference model.
module tb_frame_sequencer;

    localparam int CNT_W         = 13;
    localparam int PULSE_LEN     = 2;
    localparam int TIMEOUT_IN    = 32;
    localparam int TIMEOUT_LAG   = 160;
    localparam int WARMUP_FRAMES = 3;
    localparam int STAT_W        = 4;
    localparam int STAT_MAX      = (1 << STAT_W) - 1;

    localparam int PH_IDLE = 0;
    localparam int PH_PIN  = 1;
    localparam int PH_WIN  = 2;
    localparam int PH_PLAG = 3;
    localparam int PH_WLAG = 4;

    logic              clk_operation = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  sampling_cycle = CNT_W'(20);
    logic              ready_conv_in = 1'b0;
    logic              ready_lag = 1'b0;
    logic [CNT_W-1:0]  sampling_cycle_counter;
    logic              sampling_light;
    logic              enable_conv_in;
    logic              enable_lag;
    logic              enable_conv_out;
    logic              enable_cancel;
    logic              enable_sampling;
    logic              busy;
    logic [STAT_W-1:0] frame_count;
    logic [STAT_W-1:0] timeout_count;

    frame_sequencer #(
        .CNT_W        (CNT_W),
        .PULSE_LEN    (PULSE_LEN),
        .TIMEOUT_IN   (TIMEOUT_IN),
        .TIMEOUT_LAG  (TIMEOUT_LAG),
        .WARMUP_FRAMES(WARMUP_FRAMES),
        .STAT_W       (STAT_W)
    ) dut (
        .clk_operation         (clk_operation),
        .rst                   (rst),
        .sampling_cycle        (sampling_cycle),
        .ready_conv_in         (ready_conv_in),
        .ready_lag             (ready_lag),
        .sampling_cycle_counter(sampling_cycle_counter),
        .sampling_light        (sampling_light),
        .enable_conv_in        (enable_conv_in),
        .enable_lag            (enable_lag),
        .enable_conv_out       (enable_conv_out),
        .enable_cancel         (enable_cancel),
        .enable_sampling       (enable_sampling),
        .busy                  (busy),
        .frame_count           (frame_count),
        .timeout_count         (timeout_count)
    );

    always #5 clk_operation = ~clk_operation;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: position in frame, phase of the enable chain and
    // cycles already spent in that phase.
    bit m_run, m_light, m_samp, m_sticky;
    int m_cnt, m_warm, m_phase, m_el, m_frames, m_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_light = 0; m_samp = 0; m_sticky = 0;
        m_cnt = 0; m_warm = 0; m_phase = PH_IDLE; m_el = 0; m_frames = 0; m_tmo = 0;
    endtask

    function automatic int bump_tmo(input int t);
        return (t == STAT_MAX) ? t : t + 1;
    endfunction

    task automatic model_tick();
        bit fs;
        int eff;
        fs  = m_light;
        eff = (int'(sampling_cycle) < 2) ? 2 : int'(sampling_cycle);

        if (!m_run) m_cnt = 0;
        else if (m_cnt + 1 >= eff) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        m_run   = 1;
        m_light = (m_cnt == 0);

        if (fs && m_warm < WARMUP_FRAMES) m_warm++;
        m_samp = (m_warm >= WARMUP_FRAMES);

        if (fs) begin
            if (m_phase != PH_IDLE) m_tmo = bump_tmo(m_tmo);
            m_phase = PH_PIN;
            m_el    = 0;
        end else if (m_phase == PH_PIN || m_phase == PH_PLAG) begin
            m_el++;
            if (m_el == PULSE_LEN) begin
                m_phase = (m_phase == PH_PIN) ? PH_WIN : PH_WLAG;
                m_el    = 0;
            end
        end else if (m_phase == PH_WIN) begin
            if (ready_conv_in) begin
                m_phase = PH_PLAG;
                m_el    = 0;
            end else begin
                m_el++;
                if (m_el == TIMEOUT_IN) begin
                    m_phase = PH_IDLE;
                    m_tmo   = bump_tmo(m_tmo);
                end
            end
        end else if (m_phase == PH_WLAG) begin
            if (ready_lag) begin
                m_sticky = 1;
                m_frames = (m_frames + 1) & STAT_MAX;
                m_phase  = PH_IDLE;
            end else begin
                m_el++;
                if (m_el == TIMEOUT_LAG) begin
                    m_phase = PH_IDLE;
                    m_tmo   = bump_tmo(m_tmo);
                end
            end
        end
    endtask

    task automatic check_all();
        check("counter", 32'(sampling_cycle_counter), m_cnt);
        check("light", 32'(sampling_light), 32'(m_light));
        check("en_conv_in", 32'(enable_conv_in), 32'(m_phase == PH_PIN));
        check("en_lag", 32'(enable_lag), 32'(m_phase == PH_PLAG));
        check("en_conv_out", 32'(enable_conv_out), 32'(m_sticky));
        check("en_cancel", 32'(enable_cancel), 32'(m_sticky));
        check("en_sampling", 32'(enable_sampling), 32'(m_samp));
        check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
        check("frame_count", 32'(frame_count), m_frames);
        check("timeout_count", 32'(timeout_count), m_tmo);
        check("pulse_exclusive", 32'(enable_conv_in & enable_lag), 32'(0));
    endtask

    task automatic step();
        @(posedge clk_operation);
        if (rst) model_reset();
        else model_tick();
        #1;
        check_all();
    endtask

    initial begin
        // Reset held for 5 cycles, 20-cycle frames
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;

        // Idle readies: overruns every frame, warmup completes at third frame start
        for (int i = 0; i < 45; i++) step();

        // Long frames with ready_conv_in stuck low: input-stage timeouts
        sampling_cycle = CNT_W'(50);
        for (int i = 0; i < 150; i++) step();

        // ready_lag stuck low with 40-cycle frames: overrun out of WAIT_LAG
        sampling_cycle = CNT_W'(40);
        ready_conv_in  = 1'b1;
        for (int i = 0; i < 120; i++) step();

        // Readies arrive 3 and 10 wait cycles late
        sampling_cycle = CNT_W'(60);
        ready_conv_in  = 1'b0;
        for (int i = 0; i < 180; i++) begin
            step();
            ready_conv_in = (m_phase == PH_WIN) && (m_el >= 3);
            ready_lag     = (m_phase == PH_WLAG) && (m_el >= 10);
        end

        // Readies always high: minimum latency, frame_count wraps
        sampling_cycle = CNT_W'(20);
        ready_conv_in  = 1'b1;
        ready_lag      = 1'b1;
        for (int i = 0; i < 400; i++) step();

        // Randomized frame lengths (including shrinks and values < 2) and readies
        for (int i = 0; i < 2000; i++) begin
            step();
            if ($urandom_range(0, 49) == 0) sampling_cycle = CNT_W'($urandom_range(0, 70));
            ready_conv_in = ($urandom_range(0, 3) == 0);
            ready_lag     = ($urandom_range(0, 3) == 0);
        end

        // Minimum frame length: continuous overruns saturate timeout_count
        sampling_cycle = CNT_W'(2);
        ready_conv_in  = 1'b1;
        ready_lag      = 1'b0;
        for (int i = 0; i < 200; i++) step();

        // Make sure the sticky enables are set, then park in WAIT_LAG
        sampling_cycle = CNT_W'(200);
        ready_lag      = 1'b1;
        for (int i = 0; i < 400 && !m_sticky; i++) step();
        ready_lag = 1'b0;
        for (int i = 0; i < 400 && m_phase != PH_WLAG; i++) step();
        for (int i = 0; i < 5; i++) step();
        check("reach_wait_lag", 32'(busy && enable_conv_out && !enable_conv_in && !enable_lag),
              32'(1));

        // Asynchronous reset mid-cycle: outputs clear before the next edge
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        // Restart after reset with random readies
        sampling_cycle = CNT_W'(25);
        for (int i = 0; i < 150; i++) begin
            step();
            ready_conv_in = ($urandom_range(0, 2) == 0);
            ready_lag     = ($urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
